// File: rtl/raster_frame_sink_fp16.sv
// Receiving end of the fp16 z/c pixel raster: checks raster order, tags sof/eol/eof,
// drops broken frames with sticky flags, and re-emits pixels through a FWFT ready/valid FIFO.
module raster_frame_sink_fp16 #(
    parameter int IMAGE_WIDTH  = 50,
    parameter int IMAGE_HEIGHT = 50,
    parameter int FP_WIDTH     = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [FP_WIDTH-1:0]         z_i,
    input  logic [FP_WIDTH-1:0]         c_i,
    input  logic [15:0]                 col_i,
    input  logic [15:0]                 row_i,
    input  logic                        valid_i,
    output logic [2*FP_WIDTH-1:0]       data_o,
    output logic                        sof_o,
    output logic                        eol_o,
    output logic                        eof_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [15:0]                 frame_count_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        seq_err_o,
    output logic                        overflow_o,
    input  logic                        clear_err_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2*FP_WIDTH + 3;
    localparam int LAST_COL_INT = IMAGE_WIDTH - 1;
    localparam int LAST_ROW_INT = IMAGE_HEIGHT - 1;
    localparam logic [15:0] LAST_COL = LAST_COL_INT[15:0];
    localparam logic [15:0] LAST_ROW = LAST_ROW_INT[15:0];
    localparam logic [AW:0] DEPTH_LVL = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0] LVL_ZERO = '0;

    typedef enum logic {WAIT_SOF, IN_FRAME} state_e;

    state_e             state_q, state_d;
    logic               inValid_q;
    logic [FP_WIDTH-1:0] inZ_q, inC_q;
    logic [15:0]        inCol_q, inRow_q;
    logic [15:0]        expCol_q, expCol_d, expRow_q, expRow_d;
    logic [15:0]        frameCount_q, frameCount_d;
    logic               seqErr_q, seqErr_d, overflow_q, overflow_d;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wrPtr_q, rdPtr_q;
    logic [AW:0]        level_q, level_d;
    logic               isOrigin, isExpected, atLastCol, atLastRow;
    logic               wantWrite, doWrite, wrSof, pop, fifoFull;
    logic               seqErrSet, overflowSet;
    logic [EW-1:0]      wrEntry, rdEntry;

    // Registered input stage: a pixel sampled here is classified and written one edge later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inValid_q <= 1'b0;
            inZ_q     <= '0;
            inC_q     <= '0;
            inCol_q   <= '0;
            inRow_q   <= '0;
        end else begin
            inValid_q <= valid_i;
            inZ_q     <= z_i;
            inC_q     <= c_i;
            inCol_q   <= col_i;
            inRow_q   <= row_i;
        end
    end

    assign valid_o  = (level_q != LVL_ZERO);
    assign pop      = valid_o && ready_i;
    assign fifoFull = (level_q == DEPTH_LVL);
    assign isOrigin   = (inCol_q == 16'd0) && (inRow_q == 16'd0);
    assign isExpected = (inCol_q == expCol_q) && (inRow_q == expRow_q);
    assign atLastCol  = (inCol_q == LAST_COL);
    assign atLastRow  = (inRow_q == LAST_ROW);

    always_comb begin
        state_d      = state_q;
        expCol_d     = expCol_q;
        expRow_d     = expRow_q;
        frameCount_d = frameCount_q;
        wantWrite    = 1'b0;
        wrSof        = 1'b0;
        seqErrSet    = 1'b0;
        overflowSet  = 1'b0;
        doWrite      = 1'b0;

        if (inValid_q) begin
            case (state_q)
                WAIT_SOF: begin
                    if (isOrigin) begin
                        wantWrite = 1'b1;
                        wrSof     = 1'b1;
                    end
                end
                IN_FRAME: begin
                    if (isExpected) begin
                        wantWrite = 1'b1;
                    end else begin
                        // An out-of-place origin restarts the frame instead of being lost.
                        seqErrSet = 1'b1;
                        if (isOrigin) begin
                            wantWrite = 1'b1;
                            wrSof     = 1'b1;
                        end else begin
                            state_d = WAIT_SOF;
                        end
                    end
                end
                default: state_d = WAIT_SOF;
            endcase
        end

        doWrite = wantWrite && (!fifoFull || pop);

        if (wantWrite && !doWrite) begin
            overflowSet = 1'b1;
            state_d     = WAIT_SOF;
        end else if (doWrite) begin
            if (atLastCol && atLastRow) begin
                frameCount_d = frameCount_q + 16'd1;
                state_d      = WAIT_SOF;
            end else begin
                state_d = IN_FRAME;
                if (atLastCol) begin
                    expCol_d = 16'd0;
                    expRow_d = inRow_q + 16'd1;
                end else begin
                    expCol_d = inCol_q + 16'd1;
                    expRow_d = inRow_q;
                end
            end
        end

        seqErr_d   = seqErrSet   || (seqErr_q   && !clear_err_i);
        overflow_d = overflowSet || (overflow_q && !clear_err_i);
        level_d    = level_q + {{AW{1'b0}}, doWrite} - {{AW{1'b0}}, pop};
    end

    assign wrEntry = {wrSof, atLastCol, atLastCol && atLastRow, inC_q, inZ_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= WAIT_SOF;
            expCol_q     <= '0;
            expRow_q     <= '0;
            frameCount_q <= '0;
            seqErr_q     <= 1'b0;
            overflow_q   <= 1'b0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            expCol_q     <= expCol_d;
            expRow_q     <= expRow_d;
            frameCount_q <= frameCount_d;
            seqErr_q     <= seqErr_d;
            overflow_q   <= overflow_d;
            level_q      <= level_d;
            if (doWrite) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (pop)     rdPtr_q <= rdPtr_q + PTR_ONE;
        end
    end

    // Storage needs no reset; the level counter alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (doWrite) mem_q[wrPtr_q] <= wrEntry;
    end

    assign rdEntry       = mem_q[rdPtr_q];
    assign data_o        = valid_o ? rdEntry[2*FP_WIDTH-1:0] : '0;
    assign sof_o         = valid_o && rdEntry[EW-1];
    assign eol_o         = valid_o && rdEntry[EW-2];
    assign eof_o         = valid_o && rdEntry[EW-3];
    assign frame_count_o = frameCount_q;
    assign fifo_level_o  = level_q;
    assign seq_err_o     = seqErr_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_raster_frame_sink_fp16.sv
// Self-checking bench for raster_frame_sink_fp16: a queue-based frame model checked every
// cycle, plus literal expectations for the directed raster scenarios.
module tb_raster_frame_sink_fp16;
    localparam int W = 4;
    localparam int H = 3;
    localparam int D = 4;
    localparam int FPW = 16;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [FPW-1:0]    z_i = '0, c_i = '0;
    logic [15:0]       col_i = '0, row_i = '0;
    logic              valid_i = 1'b0, ready_i = 1'b0, clear_err_i = 1'b0;
    logic [2*FPW-1:0]  data_o;
    logic              sof_o, eol_o, eof_o, valid_o, seq_err_o, overflow_o;
    logic [15:0]       frame_count_o;
    logic [$clog2(D):0] fifo_level_o;

    raster_frame_sink_fp16 #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FP_WIDTH(FPW), .FIFO_DEPTH(D)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .z_i(z_i), .c_i(c_i), .col_i(col_i), .row_i(row_i),
        .valid_i(valid_i), .data_o(data_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
        .valid_o(valid_o), .ready_i(ready_i), .frame_count_o(frame_count_o),
        .fifo_level_o(fifo_level_o), .seq_err_o(seq_err_o), .overflow_o(overflow_o),
        .clear_err_i(clear_err_i)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: output words live in a queue, raster position is a linear index.
    typedef struct packed {logic sof; logic eol; logic eof; logic [2*FPW-1:0] data;} word_t;
    word_t       modelQ[$];
    bit          modelLive = 0;
    bit          pendValid = 0;
    int          pendCol, pendRow;
    logic [2*FPW-1:0] pendData;
    bit          inFrame = 0;
    int          expIdx = 0;
    bit          mSeq = 0, mOvf = 0;
    logic [15:0] mFc = '0;
    int          wordsOut = 0, eolOut = 0, eofOut = 0;

    initial begin
        bit mPop, mFull, want, isOrigin, matched, setSeq, setOvf;
        word_t w;
        forever begin
            @(posedge clk);
            if (rst_i) begin
                modelQ.delete();
                pendValid = 0; inFrame = 0; expIdx = 0;
                mSeq = 0; mOvf = 0; mFc = '0; modelLive = 1;
            end else if (modelLive) begin
                mPop = (modelQ.size() != 0) && ready_i;
                mFull = (modelQ.size() >= D);
                setSeq = 0; setOvf = 0; want = 0; isOrigin = 0;
                if (pendValid) begin
                    isOrigin = (pendCol == 0) && (pendRow == 0);
                    matched = inFrame && (pendCol == expIdx % W) && (pendRow == expIdx / W);
                    if (!inFrame) want = isOrigin;
                    else if (matched) want = 1;
                    else begin
                        setSeq = 1;
                        want = isOrigin;
                        if (!isOrigin) inFrame = 0;
                    end
                end
                if (mPop) begin
                    w = modelQ.pop_front();
                    wordsOut++;
                    if (w.eol) eolOut++;
                    if (w.eof) eofOut++;
                end
                if (want) begin
                    if (!mFull || mPop) begin
                        w.sof = isOrigin;
                        w.eol = (pendCol == W-1);
                        w.eof = w.eol && (pendRow == H-1);
                        w.data = pendData;
                        modelQ.push_back(w);
                        if (w.eof) begin mFc = mFc + 16'd1; inFrame = 0; end
                        else begin inFrame = 1; expIdx = pendRow*W + pendCol + 1; end
                    end else begin
                        setOvf = 1;
                        inFrame = 0;
                    end
                end
                mSeq = setSeq || (mSeq && !clear_err_i);
                mOvf = setOvf || (mOvf && !clear_err_i);
                pendValid = valid_i;
                pendCol = int'(col_i);
                pendRow = int'(row_i);
                pendData = {c_i, z_i};
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (modelLive) begin
                checkOutput("valid_o", valid_o, modelQ.size() != 0);
                if (modelQ.size() != 0) begin
                    checkOutput("data_o", data_o, modelQ[0].data);
                    checkOutput("sof_o", sof_o, modelQ[0].sof);
                    checkOutput("eol_o", eol_o, modelQ[0].eol);
                    checkOutput("eof_o", eof_o, modelQ[0].eof);
                end
                checkOutput("fifo_level_o", fifo_level_o, modelQ.size());
                checkOutput("frame_count_o", frame_count_o, mFc);
                checkOutput("seq_err_o", seq_err_o, mSeq);
                checkOutput("overflow_o", overflow_o, mOvf);
            end
        end
    end

    bit randReady = 0;
    bit readyLevel = 0;

    task automatic applyStimulus(input int col, input int row, input bit v);
        col_i = col[15:0];
        row_i = row[15:0];
        valid_i = v;
        z_i = FPW'($urandom);
        c_i = FPW'($urandom);
        ready_i = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic sendFrame(input int gapPct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                while (int'($urandom_range(0, 99)) < gapPct) idle(1);
                applyStimulus(c, r, 1'b1);
            end
    endtask

    initial begin
        @(negedge clk); #1;
        rst_i = 1'b1;
        idle(3);
        checkOutput("reset valid_o", valid_o, 0);
        checkOutput("reset level", fifo_level_o, 0);
        checkOutput("reset frame_count", frame_count_o, 0);
        checkOutput("reset seq_err", seq_err_o, 0);
        rst_i = 1'b0;
        readyLevel = 1;
        idle(2);

        // Full raster, downstream always ready, two-cycle first-word latency.
        applyStimulus(0, 0, 1'b1);
        checkOutput("latency valid after 1 edge", valid_o, 0);
        applyStimulus(1, 0, 1'b1);
        checkOutput("latency valid after 2 edges", valid_o, 1);
        checkOutput("latency sof", sof_o, 1);
        for (int i = 2; i < W*H; i++) applyStimulus(i % W, i / W, 1'b1);
        idle(4);
        checkOutput("t1 frame_count", frame_count_o, 1);
        checkOutput("t1 words out", wordsOut, 12);
        checkOutput("t1 eol count", eolOut, 3);
        checkOutput("t1 eof count", eofOut, 1);
        checkOutput("t1 overflow", overflow_o, 0);

        // Stream joined mid-frame: leading pixels dropped silently.
        for (int i = 6; i < W*H; i++) applyStimulus(i % W, i / W, 1'b1);
        sendFrame(0);
        idle(4);
        checkOutput("t2 seq_err", seq_err_o, 0);
        checkOutput("t2 frame_count", frame_count_o, 2);
        checkOutput("t2 words out", wordsOut, 24);

        // Skipped pixel raises seq_err; clear returns it to 0.
        applyStimulus(0, 0, 1'b1);
        applyStimulus(1, 0, 1'b1);
        applyStimulus(3, 0, 1'b1);
        applyStimulus(0, 1, 1'b1);
        applyStimulus(1, 1, 1'b1);
        idle(3);
        checkOutput("t3 seq_err set", seq_err_o, 1);
        checkOutput("t3 frame_count", frame_count_o, 2);
        checkOutput("t3 words out", wordsOut, 26);
        clear_err_i = 1'b1;
        idle(1);
        clear_err_i = 1'b0;
        idle(1);
        checkOutput("t3 seq_err cleared", seq_err_o, 0);

        // Origin arriving mid-frame restarts the frame.
        applyStimulus(0, 0, 1'b1);
        applyStimulus(1, 0, 1'b1);
        sendFrame(0);
        idle(4);
        checkOutput("t3b seq_err", seq_err_o, 1);
        checkOutput("t3b frame_count", frame_count_o, 3);
        clear_err_i = 1'b1;
        idle(1);
        clear_err_i = 1'b0;

        // Stalled downstream with a 4-deep FIFO: overflow, frame not counted.
        readyLevel = 0;
        sendFrame(0);
        idle(3);
        checkOutput("t4 level", fifo_level_o, 4);
        checkOutput("t4 overflow", overflow_o, 1);
        checkOutput("t4 frame_count", frame_count_o, 3);
        checkOutput("t4 held sof", sof_o, 1);
        readyLevel = 1;
        clear_err_i = 1'b1;
        idle(1);
        clear_err_i = 1'b0;
        idle(6);
        checkOutput("t4 drained level", fifo_level_o, 0);
        checkOutput("t4 overflow cleared", overflow_o, 0);
        sendFrame(0);
        idle(4);
        checkOutput("t4 next frame", frame_count_o, 4);

        // Random backpressure and input gaps over three frames.
        randReady = 1;
        for (int f = 0; f < 3; f++) sendFrame(60);
        randReady = 0;
        idle(10);

        // Random coordinate noise with occasional error clears.
        randReady = 1;
        for (int i = 0; i < 300; i++) begin
            clear_err_i = ($urandom_range(0, 15) == 0);
            applyStimulus(int'($urandom_range(0, W)), int'($urandom_range(0, H)),
                          1'($urandom_range(0, 3) != 0));
        end
        clear_err_i = 1'b0;
        randReady = 0;
        idle(10);

        // Reset mid-frame discards buffered data.
        readyLevel = 0;
        for (int i = 0; i < 5; i++) applyStimulus(i % W, i / W, 1'b1);
        rst_i = 1'b1;
        idle(1);
        checkOutput("t6 valid after reset", valid_o, 0);
        checkOutput("t6 level after reset", fifo_level_o, 0);
        checkOutput("t6 frame_count after reset", frame_count_o, 0);
        rst_i = 1'b0;
        readyLevel = 1;
        sendFrame(0);
        idle(4);
        checkOutput("t6 clean frame", frame_count_o, 1);
        checkOutput("t6 seq_err", seq_err_o, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
